// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the IO address/data registers and strobe handshake
// between CPU port 0 and DMA port 1 with round-robin arbitration, a fixed
// SETUP/STROBE sequence, and an ack-or-timeout completion.
module io_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [7:0]  addr0,
    input  logic [15:0] wdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [7:0]  io_addr,
    output logic [15:0] io_data,
    output logic        io_rd,
    output logic        io_wr,
    input  logic        io_ack,
    input  logic [15:0] io_rdata
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DW-1:0]    RD_ERR   = DW'(16'hFFFF);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             last, last_nx;   // port served most recently
    logic             sel, sel_nx;     // port currently owning the bus
    logic             we, we_nx;
    logic             pick;
    logic             gnt0_nx, gnt1_nx, done0_nx, done1_nx, err_nx, busy_nx;
    logic             io_rd_nx, io_wr_nx;
    logic [DW-1:0]    rdata_nx, io_data_nx;
    logic [AW-1:0]    io_addr_nx;

    // Next-state and next-output logic for the IDLE/SETUP/STROBE/DONE sequence
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        last_nx    = last;
        sel_nx     = sel;
        we_nx      = we;
        pick       = 1'b0;
        gnt0_nx    = gnt0;
        gnt1_nx    = gnt1;
        done0_nx   = 1'b0;
        done1_nx   = 1'b0;
        err_nx     = err;
        busy_nx    = busy;
        rdata_nx   = rdata;
        io_addr_nx = io_addr;
        io_data_nx = io_data;
        io_rd_nx   = 1'b0;
        io_wr_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // on contention the port not served last wins
                    pick       = (req0 && req1) ? ~last : req1;
                    sel_nx     = pick;
                    we_nx      = pick ? we1 : we0;
                    io_addr_nx = pick ? addr1 : addr0;
                    if (we_nx) begin
                        io_data_nx = pick ? wdata1 : wdata0;
                    end
                    gnt0_nx  = ~pick;
                    gnt1_nx  = pick;
                    busy_nx  = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                io_wr_nx = we;
                io_rd_nx = ~we;
                state_nx = STROBE;
            end
            STROBE: begin
                if (io_ack || (cnt == CNT_LAST)) begin
                    // ack wins over a simultaneous timeout
                    err_nx = ~io_ack;
                    if (!we) begin
                        rdata_nx = io_ack ? io_rdata : RD_ERR;
                    end
                    done0_nx = ~sel;
                    done1_nx = sel;
                    last_nx  = sel;
                    state_nx = DONE;
                end else begin
                    cnt_nx   = cnt + CNT_W'(1);
                    io_wr_nx = we;
                    io_rd_nx = ~we;
                end
            end
            DONE: begin
                gnt0_nx  = 1'b0;
                gnt1_nx  = 1'b0;
                busy_nx  = 1'b0;
                cnt_nx   = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            last    <= 1'b1;
            sel     <= 1'b0;
            we      <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= '0;
            io_addr <= '0;
            io_data <= '0;
            io_rd   <= 1'b0;
            io_wr   <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            last    <= last_nx;
            sel     <= sel_nx;
            we      <= we_nx;
            gnt0    <= gnt0_nx;
            gnt1    <= gnt1_nx;
            done0   <= done0_nx;
            done1   <= done1_nx;
            err     <= err_nx;
            busy    <= busy_nx;
            rdata   <= rdata_nx;
            io_addr <= io_addr_nx;
            io_data <= io_data_nx;
            io_rd   <= io_rd_nx;
            io_wr   <= io_wr_nx;
        end
    end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Testbench for io_bus_arbiter: random two-port traffic against a
// transaction-level timing model, with a done-event scoreboard and a
// per-cycle check of the bus control outputs.
module tb_io_bus_arbiter;
    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        io_ack = 1'b0;
    logic [15:0] io_rdata = '0;
    logic        gnt0, gnt1, done0, done1, err, busy, io_rd, io_wr;
    logic [15:0] rdata, io_data;
    logic [7:0]  io_addr;

    io_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .rdata(rdata), .busy(busy),
        .io_addr(io_addr), .io_data(io_data), .io_rd(io_rd), .io_wr(io_wr),
        .io_ack(io_ack), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        port;
        logic        err;
        logic [15:0] rdata;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // reference model: one transaction at a time, timing in edge numbers
    int          cyc = 0;
    bit          m_act = 0;
    int          t_start = 0, t_done = 0, t_ack = -1, m_d = 0;
    bit          m_port = 0, m_we = 0, m_err = 0;
    bit          m_last = 1;
    int          idle_from = 0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_data = '0, m_rdata = '0;
    int          acc_cnt [2] = '{0, 0};
    int          done_cnt[2] = '{0, 0};
    int          txn_n = 0;
    bit          force_timeout = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, cyc);
        end
    endtask

    // model update at each edge, from the inputs the bench is driving
    always @(posedge clk) begin
        if (rst) begin
            m_act = 0; m_last = 1; idle_from = cyc + 1;
            m_addr = '0; m_data = '0; m_rdata = '0;
        end else if (m_act && cyc == t_done) begin
            if (!m_we) m_rdata = (t_ack >= 0) ? io_rdata : 16'hFFFF;
            m_last = m_port;
            sb_q.push_back({m_port, m_err, m_rdata, m_addr, m_data});
            done_cnt[m_port]++;
            idle_from = cyc + 2;
        end else if (m_act && cyc == t_done + 1) begin
            m_act = 0;
        end else if (!m_act && cyc >= idle_from && (req0 || req1)) begin
            m_port = (req0 && req1) ? !m_last : req1;
            m_we   = m_port ? we1 : we0;
            m_addr = m_port ? addr1 : addr0;
            if (m_we) m_data = m_port ? wdata1 : wdata0;
            if (force_timeout || txn_n % 8 == 6) m_d = TIMEOUT + 1;
            else if (txn_n % 8 == 3) m_d = TIMEOUT;
            else if ($urandom % 4 == 0) m_d = int'($urandom_range(1, TIMEOUT + 3));
            else m_d = int'($urandom_range(1, 3));
            if (m_d <= TIMEOUT) begin
                t_ack = cyc + 1 + m_d; t_done = t_ack; m_err = 0;
            end else begin
                t_ack = -1; t_done = cyc + 1 + TIMEOUT; m_err = 1;
            end
            t_start = cyc; m_act = 1;
            acc_cnt[m_port]++; txn_n++;
        end
        cyc++;
    end

    // peripheral stimulus, per-cycle output check and done scoreboard
    always @(negedge clk) begin
        int   e;
        logic strobe_e, done_e;
        exp_t ex;
        e = cyc - 1;
        io_rdata = 16'($urandom);
        if (m_act && cyc >= t_start + 2 && cyc <= t_done) io_ack = (cyc == t_ack);
        else io_ack = ($urandom % 4 == 0);
        strobe_e = m_act && (e >= t_start + 1) && (e <= t_done - 1);
        done_e   = m_act && (e == t_done);
        check("bus_cycle",
              64'({gnt0, gnt1, busy, io_rd, io_wr, done0, done1, io_addr, io_data, rdata}),
              64'({m_act && !m_port, m_act && m_port, m_act, strobe_e && !m_we, strobe_e && m_we,
                   done_e && !m_port, done_e && m_port, m_addr, m_data, m_rdata}));
        if (done0 || done1) begin
            if (sb_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL sb_unexpected_done: got done0=%b done1=%b expected none (edge %0d)",
                         done0, done1, cyc);
            end else begin
                ex = sb_q.pop_front();
                check("sb_done",
                      64'({done0, done1, err, rdata, io_addr, io_data}),
                      64'({!ex.port, ex.port, ex.err, ex.rdata, ex.addr, ex.data}));
            end
        end
    end

    task automatic drive(input int p, input bit r, input bit w, input logic [7:0] a,
                         input logic [15:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic wait_bump(input string nm, input int p, input bit on_done, input int base,
                             input int limit);
        int w = 0;
        while (((on_done ? done_cnt[p] : acc_cnt[p]) == base) && w < limit) begin
            @(negedge clk);
            w++;
        end
        if ((on_done ? done_cnt[p] : acc_cnt[p]) == base) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: port %0d got no event expected one within %0d cycles", nm, p, limit);
        end
    endtask

    task automatic run_port(input int p, input int ntx);
        bit keep = 0;
        int base;
        for (int n = 0; n < ntx; n++) begin
            if (!keep) repeat ($urandom_range(0, 4)) @(negedge clk);
            drive(p, 1'b1, 1'($urandom), 8'($urandom), 16'($urandom));
            base = acc_cnt[p];
            wait_bump("accept", p, 1'b0, base, 400);
            // after the grant: scramble inputs, sometimes drop req in SETUP
            base = done_cnt[p];
            drive(p, ($urandom % 4 != 0), 1'($urandom), 8'($urandom), 16'($urandom));
            wait_bump("complete", p, 1'b1, base, 100);
            keep = 1'($urandom);
            if (!keep) drive(p, 1'b0, 1'b0, 8'h00, 16'h0000);
        end
        drive(p, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // main sequence
    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({gnt0, gnt1, done0, done1, err, busy, io_rd, io_wr, rdata, io_addr, io_data}),
              64'(0));
        rst = 1'b0;

        fork
            run_port(0, 60);
            run_port(1, 60);
        join
        repeat (25) @(negedge clk);

        // port 0 read completes normally so port 0 is the last served
        base = acc_cnt[0];
        drive(0, 1'b1, 1'b0, 8'h33, 16'h0000);
        wait_bump("dir_read_accept", 0, 1'b0, base, 50);
        base = done_cnt[0];
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        wait_bump("dir_read_done", 0, 1'b1, base, 50);

        // port 0 write with no ack, reset in the second STROBE cycle
        force_timeout = 1;
        base = acc_cnt[0];
        drive(0, 1'b1, 1'b1, 8'h12, 16'hBEEF);
        wait_bump("rst_wr_accept", 0, 1'b0, base, 50);
        force_timeout = 0;
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        repeat (2) @(negedge clk);
        check("wr_before_reset", 64'({io_wr, gnt0, busy, io_addr, io_data}),
              64'({1'b1, 1'b1, 1'b1, 8'h12, 16'hBEEF}));
        rst = 1'b1;
        @(negedge clk);
        check("after_reset", 64'({io_wr, io_rd, gnt0, gnt1, busy, done0, done1}), 64'(0));
        rst = 1'b0;

        // both request after reset: port 0 must win
        base = acc_cnt[0];
        drive(0, 1'b1, 1'b1, 8'h5A, 16'hA5A5);
        drive(1, 1'b1, 1'b1, 8'hC3, 16'h3C3C);
        wait_bump("post_reset_accept", 0, 1'b0, base, 50);
        check("post_reset_winner", 64'({gnt0, gnt1}), 64'(2'b10));
        base = done_cnt[0];
        drive(0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive(1, 1'b0, 1'b0, 8'h00, 16'h0000);
        wait_bump("post_reset_done", 0, 1'b1, base, 50);
        repeat (5) @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
